// File: rtl/metropolis_acceptor.sv
// Metropolis accept/reject stage: takes one proposed move, decides against the committed state,
// commits accepted moves and keeps saturating accept/reject statistics.
module metropolis_acceptor #(
    parameter int unsigned MAX_BIT_WIDTH_OF_VARIABLES_INDEX  = 2,
    parameter int unsigned MAX_BIT_WIDTH_OF_INTEGER_VARIABLE = 8,
    parameter int unsigned COST_WIDTH                        = 8,
    parameter int unsigned RAND_WIDTH                        = 8,
    parameter int unsigned COUNT_WIDTH                       = 16,
    localparam int unsigned NUM_VARS = 2 ** MAX_BIT_WIDTH_OF_VARIABLES_INDEX,
    localparam int unsigned IW       = MAX_BIT_WIDTH_OF_INTEGER_VARIABLE
) (
    input  logic                                        in_clock,
    input  logic                                        in_reset,
    input  logic [RAND_WIDTH-1:0]                       in_seed,
    input  logic                                        in_load_enable,
    input  logic [NUM_VARS-1:0]                         in_initial_boolean_assignment,
    input  logic [NUM_VARS*IW-1:0]                      in_initial_integer_assignment,
    input  logic [COST_WIDTH-1:0]                       in_initial_cost,
    input  logic [2:0]                                  in_temperature_shift,
    input  logic                                        in_proposal_valid,
    output logic                                        out_proposal_ready,
    input  logic                                        in_is_integer_move,
    input  logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0] in_variable_to_be_changed_index,
    input  logic [NUM_VARS-1:0]                         in_boolean_assignment_proposed_move,
    input  logic [IW-1:0]                               in_integer_proposed_value,
    input  logic [COST_WIDTH-1:0]                       in_proposed_cost,
    output logic [NUM_VARS-1:0]                         out_boolean_assignment,
    output logic [NUM_VARS*IW-1:0]                      out_integer_assignment,
    output logic [COST_WIDTH-1:0]                       out_current_cost,
    output logic                                        out_decision_valid,
    output logic                                        out_accepted,
    output logic [COUNT_WIDTH-1:0]                      out_accept_count,
    output logic [COUNT_WIDTH-1:0]                      out_reject_count
);

    localparam int unsigned DW = COST_WIDTH + 1;
    localparam int unsigned PW = COST_WIDTH + 3;
    localparam int unsigned KW = $clog2(RAND_WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVAL,
        S_DRAW,
        S_ACCEPT,
        S_REJECT
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                                        r_prop_is_int;
    logic [MAX_BIT_WIDTH_OF_VARIABLES_INDEX-1:0] r_prop_index;
    logic [NUM_VARS-1:0]                         r_prop_bool;
    logic [IW-1:0]                               r_prop_int;
    logic [COST_WIDTH-1:0]                       r_prop_cost;
    logic [KW-1:0]                               r_k;
    logic [RAND_WIDTH-1:0]                       r_lfsr;

    logic [DW-1:0]         w_delta;
    logic                  w_uphill;
    logic [PW-1:0]         w_prod;
    logic [KW-1:0]         w_k;
    logic [RAND_WIDTH-1:0] w_lfsr_next;
    logic                  w_draw_accept;

    // Signed cost difference; one extra bit so it never wraps
    assign w_delta  = {1'b0, r_prop_cost} - {1'b0, out_current_cost};
    assign w_uphill = ~w_delta[DW-1] & (|w_delta);
    assign w_prod   = PW'(w_delta[COST_WIDTH-1:0]) * PW'(in_temperature_shift);
    assign w_k      = (w_prod >= PW'(RAND_WIDTH)) ? KW'(RAND_WIDTH) : KW'(w_prod);

    // Taps 8,6,5,4 of the 8-bit Fibonacci LFSR
    assign w_lfsr_next = {r_lfsr[RAND_WIDTH-2:0],
                          r_lfsr[RAND_WIDTH-1] ^ r_lfsr[RAND_WIDTH-3] ^
                          r_lfsr[RAND_WIDTH-4] ^ r_lfsr[RAND_WIDTH-5]};

    // Accept with probability 2^-k: the top k bits of the fresh draw must all be zero
    assign w_draw_accept = (r_k == '0) ||
                           ((r_k < KW'(RAND_WIDTH)) &&
                            ((w_lfsr_next >> (KW'(RAND_WIDTH) - r_k)) == '0));

    assign out_proposal_ready = (r_state == S_IDLE) & ~in_load_enable;
    assign out_decision_valid = (r_state == S_ACCEPT) | (r_state == S_REJECT);
    assign out_accepted       = (r_state == S_ACCEPT);

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!in_load_enable && in_proposal_valid) begin
                    w_state_next = S_EVAL;
                end
            end
            S_EVAL:   w_state_next = w_uphill ? S_DRAW : S_ACCEPT;
            S_DRAW:   w_state_next = w_draw_accept ? S_ACCEPT : S_REJECT;
            S_ACCEPT: w_state_next = S_IDLE;
            S_REJECT: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Holding registers, LFSR, committed assignment and statistics
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            r_prop_is_int          <= 1'b0;
            r_prop_index           <= '0;
            r_prop_bool            <= '0;
            r_prop_int             <= '0;
            r_prop_cost            <= '0;
            r_k                    <= '0;
            r_lfsr                 <= (in_seed == '0) ? RAND_WIDTH'(1) : in_seed;
            out_boolean_assignment <= '0;
            out_integer_assignment <= '0;
            out_current_cost       <= '0;
            out_accept_count       <= '0;
            out_reject_count       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_load_enable) begin
                        out_boolean_assignment <= in_initial_boolean_assignment;
                        out_integer_assignment <= in_initial_integer_assignment;
                        out_current_cost       <= in_initial_cost;
                        out_accept_count       <= '0;
                        out_reject_count       <= '0;
                    end else if (in_proposal_valid) begin
                        r_prop_is_int <= in_is_integer_move;
                        r_prop_index  <= in_variable_to_be_changed_index;
                        r_prop_bool   <= in_boolean_assignment_proposed_move;
                        r_prop_int    <= in_integer_proposed_value;
                        r_prop_cost   <= in_proposed_cost;
                    end
                end
                S_EVAL: r_k <= w_k;
                S_DRAW: r_lfsr <= w_lfsr_next;
                S_ACCEPT: begin
                    if (r_prop_is_int) begin
                        out_integer_assignment[32'(r_prop_index) * IW +: IW] <= r_prop_int;
                    end else begin
                        out_boolean_assignment <= r_prop_bool;
                    end
                    out_current_cost <= r_prop_cost;
                    if (out_accept_count != '1) begin
                        out_accept_count <= out_accept_count + COUNT_WIDTH'(1);
                    end
                end
                S_REJECT: begin
                    if (out_reject_count != '1) begin
                        out_reject_count <= out_reject_count + COUNT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_metropolis_acceptor.sv
// Bench for metropolis_acceptor: directed table, reference-model random runs, load/reset corners.
module tb_metropolis_acceptor;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  seed;
    logic        load;
    logic [3:0]  init_bool;
    logic [31:0] init_ints;
    logic [7:0]  init_cost;
    logic [2:0]  tshift;
    logic        pvalid;
    logic        pready;
    logic        is_int;
    logic [1:0]  pidx;
    logic [3:0]  pbool;
    logic [7:0]  pint;
    logic [7:0]  pcost;
    logic [3:0]  o_bool;
    logic [31:0] o_ints;
    logic [7:0]  o_cost;
    logic        dvalid;
    logic        accepted;
    logic [15:0] acc_cnt;
    logic [15:0] rej_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model of the committed state
    logic [3:0]  m_bool;
    logic [31:0] m_ints;
    int          m_cost;
    logic [7:0]  m_lfsr;
    int          m_acc;
    int          m_rej;

    typedef struct {
        bit          is_int;
        logic [1:0]  idx;
        logic [3:0]  bv;
        logic [7:0]  iv;
        logic [7:0]  cost;
        logic [2:0]  sh;
        bit          exp_acc;
        int          exp_lat;
        logic [3:0]  exp_bool;
        logic [31:0] exp_ints;
        logic [7:0]  exp_cost;
        int          exp_ac;
        int          exp_rc;
    } vec_t;

    vec_t tbl[7];

    metropolis_acceptor dut (
        .in_clock                            (clk),
        .in_reset                            (rst),
        .in_seed                             (seed),
        .in_load_enable                      (load),
        .in_initial_boolean_assignment       (init_bool),
        .in_initial_integer_assignment       (init_ints),
        .in_initial_cost                     (init_cost),
        .in_temperature_shift                (tshift),
        .in_proposal_valid                   (pvalid),
        .out_proposal_ready                  (pready),
        .in_is_integer_move                  (is_int),
        .in_variable_to_be_changed_index     (pidx),
        .in_boolean_assignment_proposed_move (pbool),
        .in_integer_proposed_value           (pint),
        .in_proposed_cost                    (pcost),
        .out_boolean_assignment              (o_bool),
        .out_integer_assignment              (o_ints),
        .out_current_cost                    (o_cost),
        .out_decision_valid                  (dvalid),
        .out_accepted                        (accepted),
        .out_accept_count                    (acc_cnt),
        .out_reject_count                    (rej_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    // Expected decision from the Metropolis rule; updates the model state
    task automatic model_prop(input bit mi, input logic [1:0] idx, input logic [3:0] bv,
                              input logic [7:0] iv, input logic [7:0] cost, input logic [2:0] sh,
                              output bit acc, output int lat);
        int delta;
        int k;
        delta = int'(cost) - m_cost;
        if (delta <= 0) begin
            acc = 1'b1;
            lat = 2;
        end else begin
            k = delta * int'(sh);
            if (k > 8) k = 8;
            m_lfsr = lfsr_step(m_lfsr);
            acc = (k == 0) || (k < 8 && int'(m_lfsr) < (1 << (8 - k)));
            lat = 3;
        end
        if (acc) begin
            if (mi) m_ints[int'(idx)*8 +: 8] = iv;
            else    m_bool = bv;
            m_cost = int'(cost);
            if (m_acc < 65535) m_acc++;
        end else begin
            if (m_rej < 65535) m_rej++;
        end
    endtask

    // Drive one proposal; report the decision and its latency, then settle into IDLE
    task automatic run_prop(input bit mi, input logic [1:0] idx, input logic [3:0] bv,
                            input logic [7:0] iv, input logic [7:0] cost, input logic [2:0] sh,
                            output bit got_acc, output int lat);
        is_int = mi; pidx = idx; pbool = bv; pint = iv; pcost = cost; tshift = sh;
        pvalid = 1'b1;
        #1;
        chk("ready_before_handshake", 64'(pready), 64'd1);
        step();
        pvalid = 1'b0;
        is_int = 1'($urandom); pidx = 2'($urandom); pbool = 4'($urandom);
        pint = 8'($urandom); pcost = 8'($urandom);
        lat = 1;
        while (!dvalid && lat < 8) begin
            step();
            lat++;
        end
        got_acc = accepted;
        if (!dvalid) lat = 99;
        step();
        chk("pulse_one_cycle", 64'(dvalid), 64'd0);
    endtask

    task automatic prop_vs_model(input string tag, input bit mi, input logic [1:0] idx,
                                 input logic [3:0] bv, input logic [7:0] iv,
                                 input logic [7:0] cost, input logic [2:0] sh);
        bit e_acc, g_acc;
        int e_lat, g_lat;
        model_prop(mi, idx, bv, iv, cost, sh, e_acc, e_lat);
        run_prop(mi, idx, bv, iv, cost, sh, g_acc, g_lat);
        chk({tag, "_accepted"}, 64'(g_acc), 64'(e_acc));
        chk({tag, "_latency"}, 64'(g_lat), 64'(e_lat));
        chk({tag, "_bool"}, 64'(o_bool), 64'(m_bool));
        chk({tag, "_ints"}, 64'(o_ints), 64'(m_ints));
        chk({tag, "_cost"}, 64'(o_cost), 64'(m_cost));
        chk({tag, "_acc_cnt"}, 64'(acc_cnt), 64'(m_acc));
        chk({tag, "_rej_cnt"}, 64'(rej_cnt), 64'(m_rej));
    endtask

    task automatic do_reset(input logic [7:0] s);
        seed = s;
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_lfsr = (s == 8'h00) ? 8'h01 : s;
        m_bool = '0; m_ints = '0; m_cost = 0; m_acc = 0; m_rej = 0;
    endtask

    task automatic do_load(input logic [3:0] b, input logic [31:0] ints, input logic [7:0] c);
        init_bool = b; init_ints = ints; init_cost = c;
        load = 1'b1;
        #1;
        chk("ready_low_during_load", 64'(pready), 64'd0);
        step();
        load = 1'b0;
        m_bool = b; m_ints = ints; m_cost = int'(c); m_acc = 0; m_rej = 0;
    endtask

    initial begin
        bit g_acc;
        int g_lat;
        int pulses;
        int rej_before;

        rst = 1'b0; seed = '0; load = 1'b0; init_bool = '0; init_ints = '0; init_cost = '0;
        tshift = '0; pvalid = 1'b0; is_int = 1'b0; pidx = '0; pbool = '0; pint = '0; pcost = '0;

        tbl[0] = '{1'b0, 2'd0, 4'b1011, 8'h00, 8'd7,   3'd0, 1'b1, 2, 4'b1011, 32'h44332211, 8'd7,   1, 0};
        tbl[1] = '{1'b1, 2'd2, 4'b0110, 8'h5A, 8'd7,   3'd0, 1'b1, 2, 4'b1011, 32'h445A2211, 8'd7,   2, 0};
        tbl[2] = '{1'b0, 2'd0, 4'b0000, 8'h00, 8'd8,   3'd6, 1'b1, 3, 4'b0000, 32'h445A2211, 8'd8,   3, 0};
        tbl[3] = '{1'b0, 2'd0, 4'b1111, 8'h00, 8'd9,   3'd7, 1'b0, 3, 4'b0000, 32'h445A2211, 8'd8,   3, 1};
        tbl[4] = '{1'b1, 2'd0, 4'b1111, 8'hFF, 8'd9,   3'd0, 1'b1, 3, 4'b0000, 32'h445A22FF, 8'd9,   4, 1};
        tbl[5] = '{1'b0, 2'd0, 4'b0101, 8'h00, 8'd255, 3'd0, 1'b1, 3, 4'b0101, 32'h445A22FF, 8'd255, 5, 1};
        tbl[6] = '{1'b0, 2'd0, 4'b1100, 8'h00, 8'd0,   3'd7, 1'b1, 2, 4'b1100, 32'h445A22FF, 8'd0,   6, 1};

        step();
        do_reset(8'h00);
        chk("rst_bool", 64'(o_bool), 64'd0);
        chk("rst_ints", 64'(o_ints), 64'd0);
        chk("rst_cost", 64'(o_cost), 64'd0);
        chk("rst_acc_cnt", 64'(acc_cnt), 64'd0);
        chk("rst_rej_cnt", 64'(rej_cnt), 64'd0);
        chk("rst_dvalid", 64'(dvalid), 64'd0);
        chk("rst_accepted", 64'(accepted), 64'd0);
        chk("rst_ready", 64'(pready), 64'd1);

        do_load(4'b1010, 32'h44332211, 8'd10);
        chk("load_bool", 64'(o_bool), 64'hA);
        chk("load_ints", 64'(o_ints), 64'h44332211);
        chk("load_cost", 64'(o_cost), 64'd10);

        // Directed table; the model follows along so later phases stay in step
        for (int i = 0; i < 7; i++) begin
            bit e_acc;
            int e_lat;
            model_prop(tbl[i].is_int, tbl[i].idx, tbl[i].bv, tbl[i].iv, tbl[i].cost, tbl[i].sh,
                       e_acc, e_lat);
            run_prop(tbl[i].is_int, tbl[i].idx, tbl[i].bv, tbl[i].iv, tbl[i].cost, tbl[i].sh,
                     g_acc, g_lat);
            chk($sformatf("tbl%0d_accepted", i), 64'(g_acc), 64'(tbl[i].exp_acc));
            chk($sformatf("tbl%0d_latency", i), 64'(g_lat), 64'(tbl[i].exp_lat));
            chk($sformatf("tbl%0d_bool", i), 64'(o_bool), 64'(tbl[i].exp_bool));
            chk($sformatf("tbl%0d_ints", i), 64'(o_ints), 64'(tbl[i].exp_ints));
            chk($sformatf("tbl%0d_cost", i), 64'(o_cost), 64'(tbl[i].exp_cost));
            chk($sformatf("tbl%0d_acc_cnt", i), 64'(acc_cnt), 64'(tbl[i].exp_ac));
            chk($sformatf("tbl%0d_rej_cnt", i), 64'(rej_cnt), 64'(tbl[i].exp_rc));
        end

        // Uphill by 3 at shift 3 saturates k and must always reject
        rej_before = m_rej;
        for (int i = 0; i < 20; i++) begin
            prop_vs_model("uphill3", 1'($urandom), 2'($urandom), 4'($urandom), 8'($urandom),
                          8'(m_cost + 3), 3'd3);
        end
        chk("uphill3_total_rejects", 64'(rej_cnt), 64'(rej_before + 20));

        // Coin-flip draws from seed A5
        do_reset(8'hA5);
        do_load(4'($urandom), $urandom, 8'd0);
        for (int i = 0; i < 100; i++) begin
            prop_vs_model("coin", 1'($urandom), 2'($urandom), 4'($urandom), 8'($urandom),
                          8'(m_cost + 1), 3'd1);
        end

        // Fully random proposals
        for (int i = 0; i < 60; i++) begin
            prop_vs_model("rand", 1'($urandom), 2'($urandom), 4'($urandom), 8'($urandom),
                          8'($urandom), 3'($urandom));
        end

        // Load together with a proposal: load wins and the proposal is dropped
        pvalid = 1'b1; is_int = 1'b0; pbool = 4'b1111; pcost = 8'd0; tshift = 3'd0;
        do_load(4'b0011, 32'hCAFEF00D, 8'd77);
        pvalid = 1'b0;
        chk("loadwin_bool", 64'(o_bool), 64'h3);
        chk("loadwin_ints", 64'(o_ints), 64'hCAFEF00D);
        chk("loadwin_cost", 64'(o_cost), 64'd77);
        chk("loadwin_acc_cnt", 64'(acc_cnt), 64'd0);
        chk("loadwin_rej_cnt", 64'(rej_cnt), 64'd0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (dvalid) pulses++;
            step();
        end
        chk("loadwin_no_pulse", 64'(pulses), 64'd0);

        // Reset while in DRAW aborts the proposal
        is_int = 1'b0; pbool = 4'b1000; pcost = 8'd90; tshift = 3'd1;
        pvalid = 1'b1;
        step();
        pvalid = 1'b0;
        step();
        chk("draw_no_pulse_yet", 64'(dvalid), 64'd0);
        chk("draw_not_ready", 64'(pready), 64'd0);
        do_reset(8'h00);
        chk("abort_dvalid", 64'(dvalid), 64'd0);
        chk("abort_ready", 64'(pready), 64'd1);
        chk("abort_bool", 64'(o_bool), 64'd0);
        chk("abort_cost", 64'(o_cost), 64'd0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (dvalid) pulses++;
            step();
        end
        chk("abort_no_pulse", 64'(pulses), 64'd0);
        chk("abort_acc_cnt", 64'(acc_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
